// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: turns a mnemonic ID plus register/immediate fields into an
// RV32I instruction word. Two-stage elastic pipeline: S1 captures the request,
// decodes the op and range-checks the immediate; S2 assembles the 32-bit word
// and acts as the output register. Illegal requests emit a NOP with out_err set.
module rv_instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] out_count
);

  // Instruction format classes carried from S1 to S2
  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_SH  = 3'd2;
  localparam logic [2:0] FMT_S   = 3'd3;
  localparam logic [2:0] FMT_B   = 3'd4;
  localparam logic [2:0] FMT_U   = 3'd5;
  localparam logic [2:0] FMT_J   = 3'd6;
  localparam logic [2:0] FMT_BAD = 3'd7;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Pipeline control
  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;

  // S1 captured state (imm above bit 20 is never placed in a word)
  logic [2:0]  s1_fmt;
  logic [6:0]  s1_opc;
  logic [2:0]  s1_f3;
  logic        s1_b30;
  logic        s1_err;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [20:0] s1_imm;

  // Decode results from the incoming request
  logic [2:0] dec_fmt;
  logic [6:0] dec_opc;
  logic [2:0] dec_f3;
  logic       dec_b30;
  logic       dec_err;

  // Immediate range predicates
  logic fits_12;
  logic fits_sh;
  logic fits_b;
  logic fits_j;
  logic fits_u;

  logic [31:0] asm_word;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Upper bits must be a pure sign extension of the field's top bit
  assign fits_12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign fits_sh = !(|in_imm[31:5]);
  assign fits_b  = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
  assign fits_j  = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
  assign fits_u  = !(|in_imm[31:20]);

  // Map the mnemonic ID onto format, major opcode and funct bits
  always_comb begin
    dec_fmt = FMT_BAD;
    dec_opc = 7'b0000000;
    if (in_op <= 6'd9) begin
      dec_fmt = FMT_R;
      dec_opc = 7'b0110011;
    end else if (in_op <= 6'd18) begin
      dec_fmt = (in_op == 6'd11 || in_op == 6'd15 || in_op == 6'd16) ? FMT_SH : FMT_I;
      dec_opc = 7'b0010011;
    end else if (in_op <= 6'd23) begin
      dec_fmt = FMT_I;
      dec_opc = 7'b0000011;
    end else if (in_op <= 6'd26) begin
      dec_fmt = FMT_S;
      dec_opc = 7'b0100011;
    end else if (in_op <= 6'd32) begin
      dec_fmt = FMT_B;
      dec_opc = 7'b1100011;
    end else if (in_op == 6'd33) begin
      dec_fmt = FMT_U;
      dec_opc = 7'b0110111;
    end else if (in_op == 6'd34) begin
      dec_fmt = FMT_U;
      dec_opc = 7'b0010111;
    end else if (in_op == 6'd35) begin
      dec_fmt = FMT_J;
      dec_opc = 7'b1101111;
    end else if (in_op == 6'd36) begin
      dec_fmt = FMT_I;
      dec_opc = 7'b1100111;
    end
  end

  // funct3 per mnemonic; SUB, SRA and SRAI additionally set bit 30
  always_comb begin
    dec_f3 = 3'd0;
    case (in_op)
      6'd2, 6'd11, 6'd20, 6'd25, 6'd28:              dec_f3 = 3'd1;
      6'd3, 6'd12, 6'd21, 6'd26:                     dec_f3 = 3'd2;
      6'd4, 6'd13:                                   dec_f3 = 3'd3;
      6'd5, 6'd14, 6'd22, 6'd29:                     dec_f3 = 3'd4;
      6'd6, 6'd7, 6'd15, 6'd16, 6'd23, 6'd30:        dec_f3 = 3'd5;
      6'd8, 6'd17, 6'd31:                            dec_f3 = 3'd6;
      6'd9, 6'd18, 6'd32:                            dec_f3 = 3'd7;
      default:                                       dec_f3 = 3'd0;
    endcase
    dec_b30 = (in_op == 6'd1) || (in_op == 6'd7) || (in_op == 6'd16);
  end

  // Range check selected by format; unknown IDs are always errors
  always_comb begin
    dec_err = 1'b0;
    case (dec_fmt)
      FMT_R:        dec_err = 1'b0;
      FMT_I, FMT_S: dec_err = !fits_12;
      FMT_SH:       dec_err = !fits_sh;
      FMT_B:        dec_err = !fits_b;
      FMT_U:        dec_err = !fits_u;
      FMT_J:        dec_err = !fits_j;
      default:      dec_err = 1'b1;
    endcase
  end

  // S1: capture the request together with its decode and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fmt <= dec_fmt;
        s1_opc <= dec_opc;
        s1_f3  <= dec_f3;
        s1_b30 <= dec_b30;
        s1_err <= dec_err;
        s1_rd  <= in_rd;
        s1_rs1 <= in_rs1;
        s1_rs2 <= in_rs2;
        s1_imm <= in_imm[20:0];
      end
    end
  end

  // Assemble the instruction word from the S1 fields
  always_comb begin
    asm_word = NOP_WORD;
    case (s1_fmt)
      FMT_R:  asm_word = {1'b0, s1_b30, 5'b00000, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_opc};
      FMT_I:  asm_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_opc};
      FMT_SH: asm_word = {1'b0, s1_b30, 5'b00000, s1_imm[4:0], s1_rs1, s1_f3, s1_rd, s1_opc};
      FMT_S:  asm_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_opc};
      FMT_B:  asm_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                          s1_imm[4:1], s1_imm[11], s1_opc};
      FMT_U:  asm_word = {s1_imm[19:0], s1_rd, s1_opc};
      FMT_J:  asm_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opc};
      default: asm_word = NOP_WORD;
    endcase
    if (s1_err) begin
      asm_word = NOP_WORD;
    end
  end

  // S2: output register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      out_instr <= 32'h0000_0000;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= asm_word;
        out_err   <= s1_err;
      end
    end
  end

  // Count completed output transfers, wrapping naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else if (s2_valid && out_ready) begin
      out_count <= out_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed testbench for rv_instr_encoder: hand-computed encodings, range
// errors, back-to-back streaming, back-pressure and reset with work in flight.
module tb_rv_instr_encoder;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] out_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_count = '0;

  rv_instr_encoder #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_op    = v.op;
    in_rd    = v.rd;
    in_rs1   = v.rs1;
    in_rs2   = v.rs2;
    in_imm   = v.imm;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
  endtask

  // Send one request into an empty pipe with out_ready high; report readiness,
  // the resulting word and the edge (relative to accept) at which it transfers.
  task automatic run_one(input vec_t v, output logic rdy, output logic [31:0] instr,
                         output logic err, output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    drive(v);
    #1 rdy = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 99;
    instr = 32'hxxxx_xxxx;
    err = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      if (out_valid) begin
        instr = out_instr;
        err = out_err;
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: out_valid=%b out_err=%b required 0/0", out_valid, out_err);
    end
    n_tests++;
    if (out_instr !== 32'h0 || out_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: out_instr=%h out_count=%0d required 0/0", out_instr, out_count);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    $display("[TB] reset: out_valid=%b out_count=%0d in_ready=%b", out_valid, out_count, in_ready);
    exp_count = '0;
  endtask

  task automatic test_encode();
    vec_t v[12];
    logic rdy;
    logic [31:0] instr;
    logic err;
    int lat;
    v[0]  = '{6'd10, 5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093, 1'b0}; // ADDI
    v[1]  = '{6'd0,  5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3, 1'b0}; // ADD
    v[2]  = '{6'd1,  5'd3, 5'd1, 5'd2, 32'd0,          32'h402081B3, 1'b0}; // SUB
    v[3]  = '{6'd26, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423, 1'b0}; // SW
    v[4]  = '{6'd27, 5'd0, 5'd1, 5'd2, 32'd8,          32'h00208463, 1'b0}; // BEQ
    v[5]  = '{6'd35, 5'd1, 5'd0, 5'd0, 32'd16,         32'h010000EF, 1'b0}; // JAL
    v[6]  = '{6'd33, 5'd5, 5'd0, 5'd0, 32'h0001_2345,  32'h123452B7, 1'b0}; // LUI
    v[7]  = '{6'd16, 5'd2, 5'd3, 5'd0, 32'd4,          32'h4041D113, 1'b0}; // SRAI
    v[8]  = '{6'd10, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800,  32'h80000093, 1'b0}; // ADDI -2048
    v[9]  = '{6'd27, 5'd0, 5'd1, 5'd2, 32'hFFFF_F000,  32'h80208063, 1'b0}; // BEQ -4096
    v[10] = '{6'd35, 5'd1, 5'd0, 5'd0, 32'hFFF0_0000,  32'h800000EF, 1'b0}; // JAL -2^20
    v[11] = '{6'd21, 5'd4, 5'd2, 5'd0, 32'hFFFF_FFFC,  32'hFFC12203, 1'b0}; // LW -4
    for (int i = 0; i < 12; i++) begin
      run_one(v[i], rdy, instr, err, lat);
      exp_count = exp_count + 16'd1;
      n_tests++;
      if (instr !== v[i].exp_instr || err !== v[i].exp_err) begin
        n_fail++;
        $display("FAIL encode_%0d: got %h err=%b required %h err=%b",
                 i, instr, err, v[i].exp_instr, v[i].exp_err);
      end
      n_tests++;
      if (rdy !== 1'b1 || lat !== 2) begin
        n_fail++;
        $display("FAIL latency_%0d: in_ready=%b transfer edge +%0d required 1 / +2", i, rdy, lat);
      end
      n_tests++;
      if (out_count !== exp_count) begin
        n_fail++;
        $display("FAIL count_%0d: got %0d required %0d", i, out_count, exp_count);
      end
      $display("[TB] encode op=%0d imm=%h -> %h err=%b lat=%0d count=%0d",
               v[i].op, v[i].imm, instr, err, lat, out_count);
    end
  endtask

  task automatic test_illegal();
    vec_t v[7];
    logic rdy;
    logic [31:0] instr;
    logic err;
    int lat;
    v[0] = '{6'd27, 5'd0, 5'd1, 5'd2, 32'd7,         32'h00000013, 1'b1}; // BEQ odd
    v[1] = '{6'd10, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h00000013, 1'b1}; // ADDI too big
    v[2] = '{6'd40, 5'd1, 5'd1, 5'd1, 32'd0,         32'h00000013, 1'b1}; // bad ID
    v[3] = '{6'd11, 5'd1, 5'd1, 5'd0, 32'd32,        32'h00000013, 1'b1}; // SLLI 32
    v[4] = '{6'd35, 5'd1, 5'd0, 5'd0, 32'd17,        32'h00000013, 1'b1}; // JAL odd
    v[5] = '{6'd33, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'h00000013, 1'b1}; // LUI too big
    v[6] = '{6'd27, 5'd0, 5'd1, 5'd2, 32'd4096,      32'h00000013, 1'b1}; // BEQ too far
    for (int i = 0; i < 7; i++) begin
      run_one(v[i], rdy, instr, err, lat);
      exp_count = exp_count + 16'd1;
      n_tests++;
      if (instr !== v[i].exp_instr || err !== v[i].exp_err) begin
        n_fail++;
        $display("FAIL illegal_%0d: got %h err=%b required %h err=%b",
                 i, instr, err, v[i].exp_instr, v[i].exp_err);
      end
      n_tests++;
      if (out_count !== exp_count) begin
        n_fail++;
        $display("FAIL illegal_count_%0d: got %0d required %0d", i, out_count, exp_count);
      end
      $display("[TB] illegal op=%0d imm=%h -> %h err=%b count=%0d",
               v[i].op, v[i].imm, instr, err, out_count);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[4];
    int idx = 0;
    v[0] = '{6'd0,  5'd3, 5'd1, 5'd2, 32'd0,  32'h002081B3, 1'b0};
    v[1] = '{6'd1,  5'd3, 5'd1, 5'd2, 32'd0,  32'h402081B3, 1'b0};
    v[2] = '{6'd26, 5'd0, 5'd1, 5'd2, 32'd8,  32'h0020A423, 1'b0};
    v[3] = '{6'd35, 5'd1, 5'd0, 5'd0, 32'd16, 32'h010000EF, 1'b0};
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 4) drive(v[c]);
      else in_valid = 1'b0;
      #1;
      if (c < 4) begin
        n_tests++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready_%0d: got %b required 1", c, in_ready);
        end
      end
      @(posedge clk);
      #1;
      if (out_valid === 1'b1 && idx < 4) begin
        n_tests++;
        if (out_instr !== v[idx].exp_instr || c !== idx + 1) begin
          n_fail++;
          $display("FAIL b2b_word_%0d: got %h at cycle %0d required %h at cycle %0d",
                   idx, out_instr, c, v[idx].exp_instr, idx + 1);
        end
        $display("[TB] b2b word %0d = %h at cycle %0d", idx, out_instr, c);
        idx++;
      end
    end
    exp_count = exp_count + 16'd4;
    n_tests++;
    if (idx !== 4 || out_count !== exp_count) begin
      n_fail++;
      $display("FAIL b2b_total: words=%0d count=%0d required 4 / %0d", idx, out_count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    vec_t a, b, c;
    a = '{6'd0,  5'd3, 5'd1, 5'd2, 32'd0,         32'h002081B3, 1'b0};
    b = '{6'd1,  5'd3, 5'd1, 5'd2, 32'd0,         32'h402081B3, 1'b0};
    c = '{6'd33, 5'd5, 5'd0, 5'd0, 32'h0001_2345, 32'h123452B7, 1'b0};
    do_reset();
    out_ready = 1'b0;
    drive(a);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept_a: in_ready=%b required 1", in_ready); end
    @(negedge clk);
    drive(b);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept_b: in_ready=%b required 1", in_ready); end
    @(negedge clk);
    drive(c);
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: in_ready=%b required 0", in_ready); end
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== a.exp_instr) begin
      n_fail++;
      $display("FAIL bp_hold: in_ready=%b out_valid=%b out_instr=%h required 0/1/%h",
               in_ready, out_valid, out_instr, a.exp_instr);
    end
    @(negedge clk);
    n_tests++;
    if (out_instr !== a.exp_instr || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stable: out_valid=%b out_instr=%h required 1/%h", out_valid, out_instr, a.exp_instr);
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: in_ready=%b required 1", in_ready); end
    $display("[TB] backpressure: word %h held, releasing", out_instr);
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_instr !== b.exp_instr) begin
      n_fail++;
      $display("FAIL bp_second: out_valid=%b out_instr=%h required 1/%h", out_valid, out_instr, b.exp_instr);
    end
    $display("[TB] backpressure: word %h", out_instr);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_instr !== c.exp_instr) begin
      n_fail++;
      $display("FAIL bp_third: out_valid=%b out_instr=%h required 1/%h", out_valid, out_instr, c.exp_instr);
    end
    $display("[TB] backpressure: word %h", out_instr);
    @(posedge clk);
    #1;
    exp_count = 16'd3;
    n_tests++;
    if (out_valid !== 1'b0 || out_count !== exp_count) begin
      n_fail++;
      $display("FAIL bp_done: out_valid=%b count=%0d required 0/3", out_valid, out_count);
    end
    $display("[TB] backpressure: done count=%0d", out_count);
  endtask

  task automatic test_reset_inflight();
    vec_t a;
    int stale = 0;
    a = '{6'd10, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0};
    @(negedge clk);
    out_ready = 1'b0;
    drive(a);
    @(negedge clk);
    drive(a);
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_fill: out_valid=%b required 1", out_valid);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_count !== 16'd0 || out_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_flush: out_valid=%b count=%0d instr=%h required 0/0/0",
               out_valid, out_count, out_instr);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) stale++;
    end
    n_tests++;
    if (stale !== 0 || out_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_stale: stale cycles=%0d count=%0d required 0/0", stale, out_count);
    end
    $display("[TB] reset in flight: stale=%0d count=%0d", stale, out_count);
    exp_count = '0;
  endtask

  initial begin
    test_reset();
    test_encode();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so a wedged pipeline cannot hang the run
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
